// File: rtl/spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// spike_rate_decoder
//
// Receive end of the spiking-neuron path. Counts rising edges of a spike train
// over a programmable window of clock cycles and delivers each window's count
// through a one-entry valid/ready output register. It also measures the most
// recent inter-spike interval (ISI).
//
// Parameters
//   CNT_W       width of the rate count, window length and ISI (all saturating)
//
// Ports
//   clk         in   1      system clock, all state updates on posedge
//   rst_n       in   1      asynchronous active-low reset
//   en          in   1      1 = decode; 0 = return to IDLE, partial window dropped
//   spike_in    in   1      spike train; one spike = one 0->1 transition
//   window_len  in   CNT_W  window length in cycles, 0 = 2^CNT_W
//   rate_out    out  CNT_W  spike count of the last delivered window
//   rate_valid  out  1      rate_out holds an undelivered result
//   rate_ready  in   1      consumer accepts rate_out on rate_valid & rate_ready
//   isi_out     out  CNT_W  cycles between the two most recent spike edges
//   overrun     out  1      sticky: a result was dropped, output register full
// -----------------------------------------------------------------------------
module spike_rate_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] window_len,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic [CNT_W-1:0] isi_out,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    // Window length and timer are one bit wider so a window of 2^CNT_W fits.
    state_e           state_q, state_d;
    logic             spike_prev_q;
    logic [CNT_W:0]   win_q, win_d;
    logic [CNT_W:0]   timer_q, timer_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] rate_q, rate_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] isi_cnt_q, isi_cnt_d;
    logic [CNT_W-1:0] isi_q, isi_d;
    logic             isi_armed_q, isi_armed_d;

    logic             spike_edge;
    logic [CNT_W:0]   win_len_ext;
    logic [CNT_W:0]   timer_inc;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] result;
    logic [CNT_W-1:0] isi_cnt_inc;
    logic             win_last;
    logic             can_post;

    assign spike_edge  = spike_in & ~spike_prev_q;
    assign win_len_ext = (window_len == '0) ? {1'b1, {CNT_W{1'b0}}}
                                            : {1'b0, window_len};
    assign timer_inc   = timer_q + (CNT_W+1)'(1);
    assign count_inc   = (count_q == CNT_MAX) ? CNT_MAX : count_q + CNT_W'(1);
    assign isi_cnt_inc = (isi_cnt_q == CNT_MAX) ? CNT_MAX : isi_cnt_q + CNT_W'(1);

    // The last cycle's edge belongs to the window that is ending.
    assign result      = spike_edge ? count_inc : count_q;
    assign win_last    = (state_q == COUNT) && (timer_inc == win_q);

    // A slot is free if empty, or if it is being drained this very cycle.
    assign can_post    = !valid_q || rate_ready;

    always_comb begin
        // NOTE: every _d gets a hold default first so no path can infer a latch.
        state_d     = state_q;
        win_d       = win_q;
        timer_d     = timer_q;
        count_d     = count_q;
        rate_d      = rate_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        isi_cnt_d   = isi_cnt_q;
        isi_d       = isi_q;
        isi_armed_d = isi_armed_q;

        // Window FSM
        case (state_q)
            IDLE: begin
                if (en) begin
                    win_d   = win_len_ext;
                    timer_d = '0;
                    count_d = '0;
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (!en) begin
                    timer_d = '0;
                    count_d = '0;
                    state_d = IDLE;
                end else if (win_last) begin
                    // Back-to-back windows: restart and re-sample the length now.
                    timer_d = '0;
                    count_d = '0;
                    win_d   = win_len_ext;
                end else begin
                    timer_d = timer_inc;
                    count_d = result;
                end
            end
            default: state_d = IDLE;
        endcase

        // Output register: drain first, then a post may refill the same cycle.
        if (valid_q && rate_ready) begin
            valid_d = 1'b0;
        end
        if (en && win_last) begin
            if (can_post) begin
                rate_d  = result;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        // ISI: independent of en and windows. The first edge only arms it.
        if (spike_edge) begin
            if (isi_armed_q) begin
                isi_d = isi_cnt_inc;
            end
            isi_cnt_d   = '0;
            isi_armed_d = 1'b1;
        end else if (isi_armed_q) begin
            isi_cnt_d = isi_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            spike_prev_q <= 1'b0;
            win_q        <= '0;
            timer_q      <= '0;
            count_q      <= '0;
            rate_q       <= '0;
            valid_q      <= 1'b0;
            overrun_q    <= 1'b0;
            isi_cnt_q    <= '0;
            isi_q        <= '0;
            isi_armed_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            state_q      <= state_d;
            spike_prev_q <= spike_in;
            win_q        <= win_d;
            timer_q      <= timer_d;
            count_q      <= count_d;
            rate_q       <= rate_d;
            valid_q      <= valid_d;
            overrun_q    <= overrun_d;
            isi_cnt_q    <= isi_cnt_d;
            isi_q        <= isi_d;
            isi_armed_q  <= isi_armed_d;
        end
    end

    assign rate_out   = rate_q;
    assign rate_valid = valid_q;
    assign isi_out    = isi_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_spike_rate_decoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_decoder
//
// Directed bench for spike_rate_decoder. Two instances: the default CNT_W=8
// build and a CNT_W=4 build used for the 16-cycle window and ISI saturation.
// Inputs change 1 ns after a rising edge; outputs are read at the same point,
// so after N ticks the outputs reflect the N-th rising edge.
// -----------------------------------------------------------------------------
module tb_spike_rate_decoder;

    logic       clk;
    logic       rst_n;

    logic       en, spike_in, rate_ready, rate_valid, overrun;
    logic [7:0] window_len, rate_out, isi_out;

    logic       en4, spike4, ready4, valid4, overrun4;
    logic [3:0] wl4, rate4, isi4;

    logic       tog, tog4;
    int         n_cmp;
    int         n_fail;

    spike_rate_decoder #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .spike_in   (spike_in),
        .window_len (window_len),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rate_ready),
        .isi_out    (isi_out),
        .overrun    (overrun)
    );

    spike_rate_decoder #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en4),
        .spike_in   (spike4),
        .window_len (wl4),
        .rate_out   (rate4),
        .rate_valid (valid4),
        .rate_ready (ready4),
        .isi_out    (isi4),
        .overrun    (overrun4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; toggle-mode spike trains flip once per cycle.
    task automatic ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (tog)  spike_in = ~spike_in;
            if (tog4) spike4   = ~spike4;
        end
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        en         = 1'b0;
        spike_in   = 1'b0;
        window_len = '0;
        rate_ready = 1'b0;
        tog        = 1'b0;
        en4        = 1'b0;
        spike4     = 1'b0;
        wl4        = '0;
        ready4     = 1'b0;
        tog4       = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded 100000 ns");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp  = 0;
        n_fail = 0;

        // Reset state
        do_reset();
        check("rst_rate",    rate_out,   0);
        check("rst_valid",   rate_valid, 0);
        check("rst_isi",     isi_out,    0);
        check("rst_overrun", overrun,    0);
        check("rst_valid4",  valid4,     0);

        // 1: window 10, toggling spikes, always ready. Windows are edges 2-11,
        //    12-21, 22-31 after en; each holds 5 rising edges.
        window_len = 8'd10;
        rate_ready = 1'b1;
        en         = 1'b1;
        tog        = 1'b1;
        for (int i = 1; i <= 31; i++) begin
            ticks(1);
            check("t1_valid", rate_valid, (i >= 11) && ((i - 1) % 10 == 0));
            if ((i >= 11) && ((i - 1) % 10 == 0)) check("t1_rate", rate_out, 5);
        end
        check("t1_overrun", overrun, 0);
        check("t1_isi",     isi_out, 2);

        // 2: window_len 0 means 256; spike rises in window cycle 1 and stays high.
        do_reset();
        window_len = 8'd0;
        rate_ready = 1'b1;
        en         = 1'b1;
        ticks(1);
        spike_in = 1'b1;
        ticks(255);
        check("t2_valid_256", rate_valid, 0);
        ticks(1);
        check("t2_valid_257", rate_valid, 1);
        check("t2_rate_257",  rate_out,   1);
        ticks(1);
        check("t2_valid_258", rate_valid, 0);
        ticks(255);
        check("t2_valid_513", rate_valid, 1);
        check("t2_rate_513",  rate_out,   0);

        // 3: four edges need eight cycles (a 0 between highs), so window 8 is used.
        //    Window 1 counts 4; later windows count 0 and are dropped while ready=0.
        do_reset();
        window_len = 8'd8;
        en         = 1'b1;
        tog        = 1'b1;
        ticks(9);
        check("t3_valid_w1",   rate_valid, 1);
        check("t3_rate_w1",    rate_out,   4);
        check("t3_overrun_w1", overrun,    0);
        tog      = 1'b0;
        spike_in = 1'b0;
        ticks(7);
        check("t3_overrun_mid", overrun, 0);
        ticks(1);
        check("t3_overrun_w2", overrun,    1);
        check("t3_rate_w2",    rate_out,   4);
        check("t3_valid_w2",   rate_valid, 1);
        ticks(8);
        check("t3_rate_w3",    rate_out,   4);
        check("t3_valid_w3",   rate_valid, 1);
        rate_ready = 1'b1;
        ticks(1);
        check("t3_valid_hs",   rate_valid, 0);
        check("t3_overrun_hs", overrun,    1);
        ticks(7);
        check("t3_valid_w4",   rate_valid, 1);
        check("t3_rate_w4",    rate_out,   0);

        // 4: window 8, single edge on window cycle 8; the next window posts in the
        //    same cycle as a handshake without raising overrun.
        do_reset();
        window_len = 8'd8;
        en         = 1'b1;
        ticks(8);
        spike_in = 1'b1;
        ticks(1);
        check("t4_valid_w1", rate_valid, 1);
        check("t4_rate_w1",  rate_out,   1);
        ticks(7);
        rate_ready = 1'b1;
        ticks(1);
        check("t4_valid_w2",   rate_valid, 1);
        check("t4_rate_w2",    rate_out,   0);
        check("t4_overrun_w2", overrun,    0);
        ticks(1);
        check("t4_valid_drain", rate_valid, 0);

        // 5: en dropped mid-window discards the partial count and restarts.
        do_reset();
        window_len = 8'd4;
        rate_ready = 1'b1;
        en         = 1'b1;
        ticks(1);
        spike_in = 1'b1;
        ticks(1);
        spike_in = 1'b0;
        ticks(1);
        en = 1'b0;
        ticks(1);
        en = 1'b1;
        ticks(1);
        check("t5_no_post", rate_valid, 0);
        ticks(4);
        check("t5_valid", rate_valid, 1);
        check("t5_rate",  rate_out,   0);

        // 6: edges 7 cycles apart, then reset mid-window.
        do_reset();
        window_len = 8'd10;
        en         = 1'b1;
        ticks(1);
        spike_in = 1'b1;
        ticks(1);
        spike_in = 1'b0;
        ticks(6);
        spike_in = 1'b1;
        ticks(1);
        spike_in = 1'b0;
        check("t6_isi", isi_out, 7);
        ticks(2);
        check("t6_valid_pre", rate_valid, 1);
        check("t6_rate_pre",  rate_out,   2);
        ticks(3);
        rst_n = 1'b0;
        #2;
        check("t6_rst_rate",    rate_out,   0);
        check("t6_rst_valid",   rate_valid, 0);
        check("t6_rst_isi",     isi_out,    0);
        check("t6_rst_overrun", overrun,    0);
        window_len = 8'd4;
        rate_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ticks(1);
        spike_in = 1'b1;
        ticks(1);
        spike_in = 1'b0;
        ticks(3);
        check("t6_post_valid", rate_valid, 1);
        check("t6_post_rate",  rate_out,   1);
        check("t6_post_isi",   isi_out,    0);

        // 7: window 256 toggling gives 128; CNT_W=4 build with window 16 gives 8
        //    and an ISI of 20 cycles saturates at 15.
        do_reset();
        window_len = 8'd0;
        rate_ready = 1'b1;
        en         = 1'b1;
        tog        = 1'b1;
        wl4        = 4'd0;
        ready4     = 1'b1;
        en4        = 1'b1;
        tog4       = 1'b1;
        ticks(17);
        check("t7_valid4", valid4, 1);
        check("t7_rate4",  rate4,  8);
        check("t7_isi4",   isi4,   2);
        ticks(240);
        check("t7_valid", rate_valid, 1);
        check("t7_rate",  rate_out,   128);
        tog4   = 1'b0;
        spike4 = 1'b0;
        ticks(1);
        spike4 = 1'b1;
        ticks(1);
        spike4 = 1'b0;
        ticks(19);
        spike4 = 1'b1;
        ticks(1);
        check("t7_isi4_sat", isi4, 15);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
